// File: rtl/nested_loop_counter_if.sv
// Handshake bundle for the two-level loop index generator.
// master drives the controls; slave is the counter itself.
interface nested_loop_counter_if #(
  parameter int INNER_W = 11,
  parameter int OUTER_W = 11
);
  logic               ce;
  logic               start;
  logic               abort;
  logic               step;
  logic               down;
  logic [INNER_W-1:0] inner_last;
  logic [OUTER_W-1:0] outer_last;
  logic               busy;
  logic               done;
  logic [INNER_W-1:0] o_inner;
  logic [OUTER_W-1:0] o_outer;
  logic               inner_wrap;
  logic               last_iter;

  modport master (
    output ce, start, abort, step, down,
    output inner_last, outer_last,
    input  busy, done, o_inner, o_outer,
    input  inner_wrap, last_iter
  );

  modport slave (
    input  ce, start, abort, step, down,
    input  inner_last, outer_last,
    output busy, done, o_inner, o_outer,
    output inner_wrap, last_iter
  );
endinterface

// File: rtl/nested_loop_counter.sv
// Outer/inner loop index generator with start/busy/done sequencing,
// abort, count-down mode and look-ahead terminal flags.
module nested_loop_counter #(
  parameter int DATA_WIDTH = 1025,
  parameter int INNER_W    = $clog2(DATA_WIDTH),
  parameter int OUTER_W    = $clog2(DATA_WIDTH)
) (
  input logic                  clk,
  input logic                  rst,
  nested_loop_counter_if.slave lc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [INNER_W-1:0] inner_q, inner_d;
  logic [OUTER_W-1:0] outer_q, outer_d;
  logic [INNER_W-1:0] lim_i_q, lim_i_d;
  logic [OUTER_W-1:0] lim_o_q, lim_o_d;
  logic               down_q, down_d;

  logic [INNER_W-1:0] inner_term;
  logic [OUTER_W-1:0] outer_term;
  logic [INNER_W-1:0] inner_start;
  logic [INNER_W-1:0] inner_step;
  logic [OUTER_W-1:0] outer_step;
  logic               at_inner;
  logic               at_outer;
  logic               in_run;

  // Down mode walks from the limits toward zero.
  assign inner_term  = down_q ? '0 : lim_i_q;
  assign outer_term  = down_q ? '0 : lim_o_q;
  assign inner_start = down_q ? lim_i_q : '0;

  assign inner_step = down_q ? inner_q - INNER_W'(1)
                             : inner_q + INNER_W'(1);
  assign outer_step = down_q ? outer_q - OUTER_W'(1)
                             : outer_q + OUTER_W'(1);

  assign in_run   = (state_q == S_RUN);
  assign at_inner = (inner_q == inner_term);
  assign at_outer = (outer_q == outer_term);

  always_comb begin
    state_d = state_q;
    inner_d = inner_q;
    outer_d = outer_q;
    lim_i_d = lim_i_q;
    lim_o_d = lim_o_q;
    down_d  = down_q;
    if (lc.ce) begin
      if (lc.abort && state_q != S_IDLE) begin
        state_d = S_IDLE;
        inner_d = '0;
        outer_d = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (lc.start && !lc.abort) begin
              lim_i_d = lc.inner_last;
              lim_o_d = lc.outer_last;
              down_d  = lc.down;
              inner_d = lc.down ? lc.inner_last : '0;
              outer_d = lc.down ? lc.outer_last : '0;
              state_d = S_RUN;
            end
          end
          S_RUN: begin
            if (lc.step) begin
              if (!at_inner) begin
                inner_d = inner_step;
              end else if (!at_outer) begin
                inner_d = inner_start;
                outer_d = outer_step;
              end else begin
                state_d = S_DONE;
              end
            end
          end
          S_DONE: begin
            state_d = S_IDLE;
            inner_d = '0;
            outer_d = '0;
          end
          default: begin
            state_d = S_IDLE;
            inner_d = '0;
            outer_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      inner_q <= '0;
      outer_q <= '0;
      lim_i_q <= '0;
      lim_o_q <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inner_q <= inner_d;
      outer_q <= outer_d;
      lim_i_q <= lim_i_d;
      lim_o_q <= lim_o_d;
      down_q  <= down_d;
    end
  end

  assign lc.busy       = in_run;
  assign lc.done       = (state_q == S_DONE);
  assign lc.o_inner    = inner_q;
  assign lc.o_outer    = outer_q;
  assign lc.inner_wrap = in_run && at_inner;
  assign lc.last_iter  = in_run && at_inner && at_outer;

endmodule
